fir_out_serializer: RTL and testbench
=====================================

Name: fir_out_serializer

Overview:
- Transmit-side counterpart of the FIR top-level sample input path: takes full-width filter output samples and sends them byte-serially onto the 8-bit dedicated output bus (uo_out).
- Samples are sent MSB byte first. Each byte is held for a programmable number of clocks so slow external logic can capture it.
- A small FIFO absorbs bursts from the filter core. An overflow flag records any samples dropped when the FIFO is full.

Parameters:
- SAMPLE_W, 16, sample width in bits; must be a multiple of 8, minimum 8.
- FIFO_DEPTH, 4, sample FIFO entries; must be a power of 2, minimum 2.
- BYTE_HOLD, 2, clocks each byte stays on byte_out; minimum 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- s_valid  in  1  sample valid from filter core.
- s_data  in  SAMPLE_W  sample value (two's complement; passed through as raw bits).
- s_ready  out  1  FIFO not full; a sample is accepted when s_valid && s_ready.
- ovf_clr  in  1  synchronous clear of the ovf flag.
- byte_out  out  8  current output byte.
- byte_valid  out  1  byte_out carries a valid byte.
- byte_first  out  1  the current byte is the MSB byte of a sample.
- busy  out  1  FSM in SEND, or FIFO non-empty.
- ovf  out  1  sticky flag; set when s_valid && !s_ready.

Behaviour:
- Reset (async, rst=1):
  - FIFO emptied; FSM in IDLE.
  - byte_out=0, byte_valid=0, byte_first=0, ovf=0, busy=0.
  - s_ready=1 from the first cycle after rst deasserts.
- NBYTES = SAMPLE_W/8.
- FIFO:
  - s_ready = !full, registered-count based.
  - Push at the clock edge when s_valid && s_ready.
  - A push while full is never accepted, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle on a non-full, non-empty FIFO both take effect; the count is unchanged.
- FSM states:
  - IDLE:
    - If the FIFO is non-empty: pop the head into shift register sh, set idx=0, hold=0, go to SEND.
    - Otherwise stay in IDLE with byte_valid=0.
  - SEND:
    - byte_out = sh[SAMPLE_W-1 -: 8]; byte_valid=1; byte_first=(idx==0). All three are registered.
    - hold increments each cycle. When hold==BYTE_HOLD-1: reset hold and advance.
    - Advance when idx<NBYTES-1: shift sh left by 8, idx++.
    - Advance when idx==NBYTES-1 and the FIFO is non-empty: pop the next sample directly (back-to-back, no idle cycle), idx=0.
    - Advance when idx==NBYTES-1 and the FIFO is empty: go to IDLE.
- Latency:
  - A sample accepted at edge N is popped at edge N+1 (if IDLE).
  - byte_valid and its first byte appear after edge N+2.
  - A full sample occupies NBYTES*BYTE_HOLD cycles on the bus.
- ovf:
  - Set on any cycle with s_valid && !s_ready.
  - Cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- busy = (state==SEND) || !empty.
- byte_out is zero whenever byte_valid=0.
- Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide, so full and empty are distinguishable.
- A reset mid-sample aborts immediately; the partial sample is discarded with no further bytes.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined:
  - Adds output port byte_par (1 bit) = odd parity of byte_out (XOR of the 8 bits, inverted), registered alongside byte_out.
  - byte_par is 0 in reset and whenever byte_valid=0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fir_ser_pkg:
  - State enum {S_IDLE, S_SEND}.
  - Function clog2, and constant NBYTES derived from SAMPLE_W.
- One sub-module, fir_ser_fifo: synchronous FIFO with count-based full/empty, FIFO_DEPTH and width parameters, and async active-high reset.
- FSM, shift register and flags live in fir_out_serializer.

Test Plan:
- Single sample: after reset, push s_data=16'hA55A once, BYTE_HOLD=2.
  - byte_valid rises 2 cycles after acceptance.
  - byte_out=8'hA5 for 2 cycles with byte_first=1, then 8'h5A for 2 cycles with byte_first=0.
  - Then byte_valid=0 and busy=0.
- Back-to-back: push 16'h1234 and 16'hABCD on consecutive cycles.
  - Bytes 12,34,AB,CD appear with no byte_valid gap (8 cycles total).
  - byte_first is high only on 12 and AB.
- Full/overflow: hold s_valid=1 for 10 cycles with distinct data; DEPTH=4, HOLD=2.
  - s_ready drops once the FIFO holds 4 samples and ovf=1.
  - Only the accepted samples are emitted, in order.
  - Pulse ovf_clr with s_valid=0: ovf returns to 0.
- Simultaneous ovf set and clear: s_valid=1 while full, with ovf_clr=1 in the same cycle -> ovf stays 1.
- Reset mid-operation: assert rst during the second byte of 16'hBEEF.
  - Outputs go to 0 immediately (async).
  - After release there are no residual bytes, s_ready=1 and busy=0.
- SER_PARITY_EN build: send 16'h0700.
  - byte_par=0 for byte 07 (three ones, odd count, parity bit 0).
  - byte_par=1 for byte 00.

Source files
------------

// File: rtl/fir_ser_pkg.sv
// Shared types and helpers for the FIR output byte serializer.
package fir_ser_pkg;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic int nbytes(input int sample_w);
      return sample_w / 8;
   endfunction

   localparam int SAMPLE_W_DEFAULT = 16;
   localparam int NBYTES = nbytes(SAMPLE_W_DEFAULT);

endpackage

// File: rtl/fir_ser_fifo.sv
// Sample FIFO with count-based full/empty; a push while full is always dropped.
module fir_ser_fifo
   import fir_ser_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fir_out_serializer.sv
// Byte-serial, MSB-first output of FIR samples with per-byte hold and overflow flag.
// Optional odd-parity output byte_par is built when SER_PARITY_EN is defined.
module fir_out_serializer
   import fir_ser_pkg::*;
#(
   parameter int SAMPLE_W   = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int BYTE_HOLD  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   input  logic [SAMPLE_W-1:0] s_data,
   output logic                s_ready,
   input  logic                ovf_clr,
   output logic [7:0]          byte_out,
   output logic                byte_valid,
   output logic                byte_first,
   output logic                busy,
   output logic                ovf
`ifdef SER_PARITY_EN
   ,
   output logic                byte_par
`endif
);

   localparam int NB = nbytes(SAMPLE_W);
   localparam int IW = (clog2(NB) < 1) ? 1 : clog2(NB);
   localparam int HW = (clog2(BYTE_HOLD) < 1) ? 1 : clog2(BYTE_HOLD);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NB - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(BYTE_HOLD - 1);

   state_t              state;
   logic [SAMPLE_W-1:0] sh;
   logic [SAMPLE_W-1:0] fifo_dout;
   logic [IW-1:0]       idx;
   logic [HW-1:0]       hold;
   logic                fifo_full;
   logic                fifo_empty;
   logic                last_beat;
   logic                pop;

   assign s_ready   = !fifo_full;
   assign last_beat = (state == S_SEND) && (hold == HOLD_LAST) && (idx == IDX_LAST);
   // Pop either to start from idle or to chain the next sample with no gap.
   assign pop       = !fifo_empty && ((state == S_IDLE) || last_beat);
   assign busy      = (state == S_SEND) || !fifo_empty;

   fir_ser_fifo #(
      .W     (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (s_valid),
      .pop   (pop),
      .din   (s_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         sh         <= '0;
         idx        <= '0;
         hold       <= '0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         byte_first <= 1'b0;
         ovf        <= 1'b0;
`ifdef SER_PARITY_EN
         byte_par   <= 1'b0;
`endif
      end else begin
         if (s_valid && !s_ready) ovf <= 1'b1;
         else if (ovf_clr)        ovf <= 1'b0;

         case (state)
            S_IDLE: begin
               byte_out   <= '0;
               byte_valid <= 1'b0;
               byte_first <= 1'b0;
`ifdef SER_PARITY_EN
               byte_par   <= 1'b0;
`endif
               if (!fifo_empty) begin
                  sh    <= fifo_dout;
                  idx   <= '0;
                  hold  <= '0;
                  state <= S_SEND;
               end
            end
            S_SEND: begin
               byte_out   <= sh[SAMPLE_W-1 -: 8];
               byte_valid <= 1'b1;
               byte_first <= (idx == '0);
`ifdef SER_PARITY_EN
               byte_par   <= ~(^sh[SAMPLE_W-1 -: 8]);
`endif
               if (hold == HOLD_LAST) begin
                  hold <= '0;
                  if (idx != IDX_LAST) begin
                     sh  <= sh << 8;
                     idx <= idx + 1'b1;
                  end else if (!fifo_empty) begin
                     sh  <= fifo_dout;
                     idx <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  hold <= hold + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_out_serializer.sv
// Directed bench for fir_out_serializer (SAMPLE_W=16, FIFO_DEPTH=4, BYTE_HOLD=2).
// The parity case is compiled in only when SER_PARITY_EN is defined.
module tb_fir_out_serializer;

   localparam int HOLD = 2;

   logic        clk;
   logic        rst;
   logic        s_valid;
   logic [15:0] s_data;
   logic        s_ready;
   logic        ovf_clr;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_first;
   logic        busy;
   logic        ovf;
`ifdef SER_PARITY_EN
   logic        byte_par;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int hc = 0;
   logic [8:0] exp_q[$];

   fir_out_serializer #(
      .SAMPLE_W   (16),
      .FIFO_DEPTH (4),
      .BYTE_HOLD  (HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .ovf_clr    (ovf_clr),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_first (byte_first),
      .busy       (busy),
      .ovf        (ovf)
`ifdef SER_PARITY_EN
      ,
      .byte_par   (byte_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic queue_sample(input logic [15:0] d);
      exp_q.push_back({1'b1, d[15:8]});
      exp_q.push_back({1'b0, d[7:0]});
   endtask

   task automatic wait_drained(input int budget);
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < budget) begin
         step();
         w++;
      end
      step();
      check("drained", exp_q.size(), 0);
      check("drained_bv", byte_valid, 1'b0);
      check("drained_busy", busy, 1'b0);
   endtask

   // Every byte must hold its {first, value} for HOLD cycles, in queue order.
   always @(negedge clk) begin
      if (rst) begin
         hc = 0;
      end else if (byte_valid) begin
         if (exp_q.size() == 0) begin
            check("extra_byte", byte_valid, 1'b0);
         end else begin
            check("byte", {byte_first, byte_out}, exp_q[0]);
            hc++;
            if (hc == HOLD) begin
               void'(exp_q.pop_front());
               hc = 0;
            end
         end
      end else begin
         if (hc != 0) check("short_hold", hc, 0);
         hc = 0;
         check("bo_zero", byte_out, 8'h00);
      end
   end

   logic [15:0] t3_data [10];
   logic        t3_rdy  [10];

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      ovf_clr = 1'b0;
      step();
      step();
      check("rst_bv", byte_valid, 1'b0);
      check("rst_bo", byte_out, 8'h00);
      rst = 1'b0;
      step();
      check("rst_ready", s_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_bf", byte_first, 1'b0);

      // Single sample: latency and hold.
      queue_sample(16'hA55A);
      s_valid = 1'b1;
      s_data  = 16'hA55A;
      step();
      s_valid = 1'b0;
      check("t1_lat0", byte_valid, 1'b0);
      check("t1_busy", busy, 1'b1);
      step();
      check("t1_lat1", byte_valid, 1'b0);
      step();
      check("t1_lat2", byte_valid, 1'b1);
      check("t1_first", {byte_first, byte_out}, {1'b1, 8'hA5});
      step();
      step();
      check("t1_second", {byte_first, byte_out}, {1'b0, 8'h5A});
      step();
      step();
      check("t1_end_bv", byte_valid, 1'b0);
      check("t1_end_busy", busy, 1'b0);
      check("t1_q", exp_q.size(), 0);

      // Back-to-back samples with no gap.
      queue_sample(16'h1234);
      queue_sample(16'hABCD);
      s_valid = 1'b1;
      s_data  = 16'h1234;
      step();
      s_data  = 16'hABCD;
      check("t2_ready", s_ready, 1'b1);
      step();
      s_valid = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         check("t2_valid", byte_valid, 1'b1);
         step();
      end
      check("t2_end_bv", byte_valid, 1'b0);
      check("t2_end_busy", busy, 1'b0);
      check("t2_q", exp_q.size(), 0);

      // Overflow: 10 cycles of s_valid; hand-traced acceptance pattern.
      for (int i = 0; i < 10; i++) t3_data[i] = {8'h30 + 8'(i), 8'hC0 + 8'(i)};
      t3_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      queue_sample(t3_data[0]);
      queue_sample(t3_data[1]);
      queue_sample(t3_data[2]);
      queue_sample(t3_data[3]);
      queue_sample(t3_data[4]);
      queue_sample(t3_data[6]);
      s_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_data = t3_data[i];
         check("t3_ready", s_ready, t3_rdy[i]);
         step();
      end
      s_valid = 1'b0;
      check("t3_ovf", ovf, 1'b1);
      wait_drained(100);
      check("t3_ovf_sticky", ovf, 1'b1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("t3_ovf_clr", ovf, 1'b0);

      // Overflow set and clear in the same cycle: set wins.
      s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_data = 16'h5000 + 16'(i);
         queue_sample(s_data);
         step();
      end
      check("t4_full", s_ready, 1'b0);
      s_data  = 16'h5F5F;
      ovf_clr = 1'b1;
      step();
      s_valid = 1'b0;
      ovf_clr = 1'b0;
      check("t4_ovf_set_wins", ovf, 1'b1);
      wait_drained(100);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("t4_ovf_clr", ovf, 1'b0);

      // Reset during the second byte of a sample.
      exp_q.push_back({1'b1, 8'hBE});
      s_valid = 1'b1;
      s_data  = 16'hBEEF;
      step();
      s_valid = 1'b0;
      step();
      step();
      check("t5_msb", {byte_first, byte_out}, {1'b1, 8'hBE});
      step();
      step();
      check("t5_lsb", {byte_first, byte_out}, {1'b0, 8'hEF});
      rst = 1'b1;
      #1;
      check("t5_rst_bv", byte_valid, 1'b0);
      check("t5_rst_bo", byte_out, 8'h00);
      check("t5_rst_bf", byte_first, 1'b0);
      check("t5_rst_busy", busy, 1'b0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("t5_ready", s_ready, 1'b1);
      check("t5_busy", busy, 1'b0);
      check("t5_bv", byte_valid, 1'b0);
      check("t5_q", exp_q.size(), 0);

`ifdef SER_PARITY_EN
      // Odd parity: 0x07 has three ones -> 0; 0x00 -> 1.
      queue_sample(16'h0700);
      s_valid = 1'b1;
      s_data  = 16'h0700;
      step();
      s_valid = 1'b0;
      check("t6_par_idle", byte_par, 1'b0);
      step();
      step();
      check("t6_par_07", byte_par, 1'b0);
      step();
      step();
      check("t6_par_00", byte_par, 1'b1);
      wait_drained(20);
      check("t6_par_off", byte_par, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
